// File: rtl/ad_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ad_frame_pkg
//  Purpose  : Shared constants and parser state encoding for the AD sample
//             FIFO producer (polling controller) and consumer (frame reader).
//  Revision : 1.0 - initial release
// ============================================================================
package ad_frame_pkg;

    localparam logic [7:0] CR           = 8'h0D;
    localparam logic [7:0] LF           = 8'h0A;
    localparam logic [7:0] END_MARK_DEF = 8'hCC;
    localparam int         NUM_CH_DEF   = 32;

    typedef enum logic [2:0] {
        S_SAMP    = 3'd0,
        S_MARK    = 3'd1,
        S_CR      = 3'd2,
        S_LF      = 3'd3,
        S_HUNT_CR = 3'd4,
        S_HUNT_LF = 3'd5
    } parser_state_t;

endpackage
`default_nettype wire

// File: rtl/ad_frame_bank.sv
`default_nettype none
// ============================================================================
//  Module   : ad_frame_bank
//  Purpose  : Shadow and result sample banks with single-cycle commit copy
//             and a registered read port.
//  Revision : 1.0 - initial release
// ============================================================================
module ad_frame_bank #(
    parameter int NUM_CH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_en,
    input  logic [4:0] i_wr_idx,
    input  logic [7:0] i_wr_data,
    input  logic       i_commit,
    input  logic [4:0] i_rd_ch,
    output logic [7:0] o_rd_data
);

    localparam logic [5:0] c_num_ch = 6'(NUM_CH);

    logic [7:0] r_shadow [NUM_CH];
    logic [7:0] r_result [NUM_CH];
    logic [7:0] r_rd_data;

    // The read samples r_result before a same-cycle commit lands, so a read
    // racing a commit returns the previous frame's value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= 8'h00;
                r_result[i] <= 8'h00;
            end
            r_rd_data <= 8'h00;
        end else begin
            if (i_wr_en) begin
                r_shadow[i_wr_idx] <= i_wr_data;
            end
            if (i_commit) begin
                r_result <= r_shadow;
            end
            r_rd_data <= ({1'b0, i_rd_ch} < c_num_ch) ? r_result[i_rd_ch] : 8'h00;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/ad_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : ad_frame_reader
//  Purpose  : Pops AD sample bytes from a normal-mode FIFO, parses
//             NUM_CH samples + END_MARK/CR/LF frames and commits good frames.
//  Revision : 1.0 - initial release
// ============================================================================
module ad_frame_reader
    import ad_frame_pkg::*;
#(
    parameter int         NUM_CH   = NUM_CH_DEF,
    parameter logic [7:0] END_MARK = END_MARK_DEF,
    parameter int         ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_q,
    output logic             fifo_rdreq,
    input  logic [4:0]       rd_ch,
    output logic [7:0]       rd_data,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic             synced,
    output logic [2:0]       state_dbg
);

    localparam logic [4:0] c_last_idx = 5'(NUM_CH - 1);

    parser_state_t    r_state;
    parser_state_t    w_state_nxt;
    logic [4:0]       r_idx;
    logic [4:0]       w_idx_nxt;
    logic             r_byte_vld;
    logic             r_frame_done;
    logic [15:0]      r_frame_cnt;
    logic [ERR_W-1:0] r_err_cnt;
    logic             w_shadow_we;
    logic             w_commit;
    logic             w_err;

    // enable and fifo_empty arrive registered; reset gating keeps the
    // request low while the parser is held in reset.
    assign fifo_rdreq = enable & ~fifo_empty & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_SAMP;
            r_idx        <= 5'd0;
            r_byte_vld   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 16'd0;
            r_err_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_byte_vld   <= fifo_rdreq;
            r_frame_done <= w_commit;
            if (w_commit) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_err && (r_err_cnt != {ERR_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_shadow_we = 1'b0;
        w_commit    = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_SAMP: if (r_byte_vld) begin
                w_shadow_we = 1'b1;
                if (r_idx == c_last_idx) begin
                    w_idx_nxt   = 5'd0;
                    w_state_nxt = S_MARK;
                end else begin
                    w_idx_nxt = r_idx + 5'd1;
                end
            end
            S_MARK: if (r_byte_vld) begin
                if (fifo_q == END_MARK) begin
                    w_state_nxt = S_CR;
                end else begin
                    w_err       = 1'b1;
                    w_state_nxt = (fifo_q == CR) ? S_HUNT_LF : S_HUNT_CR;
                end
            end
            S_CR: if (r_byte_vld) begin
                if (fifo_q == CR) begin
                    w_state_nxt = S_LF;
                end else begin
                    w_err       = 1'b1;
                    w_state_nxt = S_HUNT_CR;
                end
            end
            S_LF: if (r_byte_vld) begin
                if (fifo_q == LF) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_SAMP;
                end else begin
                    w_err       = 1'b1;
                    w_state_nxt = (fifo_q == CR) ? S_HUNT_LF : S_HUNT_CR;
                end
            end
            S_HUNT_CR: if (r_byte_vld && (fifo_q == CR)) begin
                w_state_nxt = S_HUNT_LF;
            end
            S_HUNT_LF: if (r_byte_vld) begin
                if (fifo_q == LF) begin
                    w_idx_nxt   = 5'd0;
                    w_state_nxt = S_SAMP;
                end else if (fifo_q != CR) begin
                    w_state_nxt = S_HUNT_CR;
                end
            end
            default: begin
                w_idx_nxt   = 5'd0;
                w_state_nxt = S_HUNT_CR;
            end
        endcase
        if (w_err) begin
            w_idx_nxt = 5'd0;
        end
    end

    ad_frame_bank #(
        .NUM_CH (NUM_CH)
    ) u_bank (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (w_shadow_we),
        .i_wr_idx  (r_idx),
        .i_wr_data (fifo_q),
        .i_commit  (w_commit),
        .i_rd_ch   (rd_ch),
        .o_rd_data (rd_data)
    );

    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;
    assign err_cnt    = r_err_cnt;
    assign synced     = (r_state != S_HUNT_CR) && (r_state != S_HUNT_LF);
    assign state_dbg  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ad_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ad_frame_reader
//  Purpose  : FIFO model + byte-stream reference model for ad_frame_reader.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ad_frame_reader;

    localparam int         NCH     = 32;
    localparam int         EW      = 2;
    localparam logic [7:0] MARK    = 8'hCC;
    localparam int         ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [7:0]    fifo_q = 8'h00;
    logic          fifo_rdreq;
    logic [4:0]    rd_ch = 5'd0;
    logic [7:0]    rd_data;
    logic          frame_done;
    logic [15:0]   frame_cnt;
    logic [EW-1:0] err_cnt;
    logic          synced;
    logic [2:0]    state_dbg;

    int checks = 0;
    int failures = 0;
    int done_pulses = 0;

    // stimulus knobs (written only by the main initial block)
    bit         starve = 0;
    bit         rand_en = 0;
    bit         rand_rd = 0;
    bit         en_req = 0;
    logic [4:0] rd_sel = 5'd0;

    logic [7:0] fq[$];

    // reference model: bytes gathered since the last sync point
    logic [7:0] mbuf[$];
    bit         m_sync = 1;
    bit         m_prev_cr = 0;
    logic [7:0] m_res[NCH];
    int         m_frames = 0;
    int         m_err = 0;
    bit         m_done = 0;
    logic [7:0] m_rd = 8'h00;
    bit         m_pend = 0;
    logic [7:0] m_pend_byte = 8'h00;

    always #10 clk = ~clk;

    ad_frame_reader #(
        .NUM_CH   (NCH),
        .END_MARK (MARK),
        .ERR_W    (EW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_rdreq (fifo_rdreq),
        .rd_ch      (rd_ch),
        .rd_data    (rd_data),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt),
        .synced     (synced),
        .state_dbg  (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mbuf.delete();
        m_sync = 1; m_prev_cr = 0; m_frames = 0; m_err = 0;
        m_done = 0; m_rd = 8'h00; m_pend = 0;
        for (int i = 0; i < NCH; i++) m_res[i] = 8'h00;
    endtask

    task automatic model_err(input logic [7:0] b);
        if (m_err < ERR_MAX) m_err++;
        m_sync = 0;
        m_prev_cr = (b == 8'h0D);
        mbuf.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        int n;
        if (m_sync) begin
            mbuf.push_back(b);
            n = mbuf.size();
            if (n == NCH + 1 && b != MARK) model_err(b);
            else if (n == NCH + 2 && b != 8'h0D) model_err(b);
            else if (n == NCH + 3) begin
                if (b == 8'h0A) begin
                    for (int i = 0; i < NCH; i++) m_res[i] = mbuf[i];
                    m_frames++;
                    m_done = 1;
                    mbuf.delete();
                end else begin
                    model_err(b);
                end
            end
        end else if (m_prev_cr && b == 8'h0A) begin
            m_sync = 1;
            m_prev_cr = 0;
            mbuf.delete();
        end else begin
            m_prev_cr = (b == 8'h0D);
        end
    endtask

    function automatic logic [2:0] exp_state();
        int n;
        if (!m_sync) return m_prev_cr ? 3'd5 : 3'd4;
        n = mbuf.size();
        if (n < NCH) return 3'd0;
        if (n == NCH) return 3'd1;
        if (n == NCH + 1) return 3'd2;
        return 3'd3;
    endfunction

    // FIFO (normal mode) plus model advance, both on the active edge
    always @(posedge clk) begin
        if (reset) begin
            model_reset();
        end else begin
            m_done = 0;
            m_rd = (rd_ch < NCH) ? m_res[rd_ch] : 8'h00;
            if (m_pend) model_byte(m_pend_byte);
            m_pend = 0;
            if (fifo_rdreq) begin
                m_pend_byte = fq.pop_front();
                m_pend = 1;
                fifo_q <= m_pend_byte;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        fifo_empty = (fq.size() == 0) || (starve && ($urandom_range(0, 2) == 0));
        enable     = rand_en ? ($urandom_range(0, 3) != 0) : en_req;
        rd_ch      = rand_rd ? 5'($urandom_range(0, 31)) : rd_sel;
    end

    always @(posedge clk) begin
        #2;
        if (!reset) begin
            check("state_dbg", 32'(state_dbg), 32'(exp_state()));
            check("synced", 32'(synced), 32'(m_sync));
            check("frame_cnt", 32'(frame_cnt), 32'(m_frames & 16'hFFFF));
            check("err_cnt", 32'(err_cnt), 32'(m_err));
            check("frame_done", 32'(frame_done), 32'(m_done));
            check("rd_data", 32'(rd_data), 32'(m_rd));
            check("rdreq_while_empty", 32'(fifo_rdreq & fifo_empty), 32'd0);
            if (frame_done) done_pulses++;
        end
    end

    task automatic push_seq(input logic [7:0] base);
        for (int i = 0; i < NCH; i++) fq.push_back(base + 8'(i));
    endtask

    task automatic push_trl(input logic [7:0] m, input logic [7:0] c, input logic [7:0] l);
        fq.push_back(m); fq.push_back(c); fq.push_back(l);
    endtask

    task automatic wait_idle(input int budget);
        bit idle = 0;
        for (int k = 0; k < budget && !idle; k++) begin
            @(negedge clk);
            idle = (fq.size() == 0) && !m_pend;
        end
        check("idle_timeout", 32'(idle), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic read_ch(input logic [4:0] ch, input string name, input logic [7:0] exp);
        rd_sel = ch;
        repeat (2) @(negedge clk);
        check(name, 32'(rd_data), 32'(exp));
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] v;
        case ($urandom_range(0, 5))
            0: v = 8'h0D;
            1: v = 8'h0A;
            2: v = MARK;
            default: v = 8'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        logic [7:0] sv[NCH];
        bit         hit;
        // reset values, with a full FIFO and enable high
        repeat (2) @(negedge clk);
        push_seq(8'h00); push_trl(MARK, 8'h0D, 8'h0A);
        en_req = 1;
        repeat (2) @(negedge clk);
        check("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_synced", 32'(synced), 32'd1);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // good frame 00..1F
        done_pulses = 0;
        reset = 0;
        wait_idle(300);
        check("good_pulses", 32'(done_pulses), 32'd1);
        check("good_frame_cnt", 32'(frame_cnt), 32'd1);
        check("good_err_cnt", 32'(err_cnt), 32'd0);
        read_ch(5'd5, "good_rd5", 8'h05);
        read_ch(5'd31, "good_rd31", 8'h1F);

        // samples equal to trailer bytes
        do_reset();
        for (int i = 0; i < NCH; i++) fq.push_back(8'h0D);
        push_trl(MARK, 8'h0D, 8'h0A);
        wait_idle(300);
        check("crsamp_frame_cnt", 32'(frame_cnt), 32'd1);
        for (int i = 0; i < NCH; i++) read_ch(5'(i), "crsamp_rd", 8'h0D);

        // bad marker then good frame 40..5F
        do_reset();
        push_seq(8'h10); push_trl(8'hAA, 8'h0D, 8'h0A);
        push_seq(8'h40); push_trl(MARK, 8'h0D, 8'h0A);
        wait_idle(400);
        check("badmark_err_cnt", 32'(err_cnt), 32'd1);
        check("badmark_frame_cnt", 32'(frame_cnt), 32'd1);
        read_ch(5'd0, "badmark_rd0", 8'h40);
        read_ch(5'd31, "badmark_rd31", 8'h5F);

        // starved FIFO
        do_reset();
        starve = 1;
        for (int i = 0; i < NCH; i++) begin
            sv[i] = 8'($urandom);
            fq.push_back(sv[i]);
        end
        push_trl(MARK, 8'h0D, 8'h0A);
        wait_idle(2000);
        starve = 0;
        check("starve_frame_cnt", 32'(frame_cnt), 32'd1);
        read_ch(5'd7, "starve_rd7", sv[7]);
        read_ch(5'd30, "starve_rd30", sv[30]);

        // reset after 10 samples
        do_reset();
        push_seq(8'h20); push_trl(MARK, 8'h0D, 8'h0A);
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            hit = m_sync && (mbuf.size() >= 10);
        end
        check("midrst_reach10", 32'(hit), 32'd1);
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        wait_idle(300);
        check("midrst_frame_cnt0", 32'(frame_cnt), 32'd0);
        read_ch(5'd3, "midrst_rd3", 8'h00);
        push_seq(8'h20); push_trl(MARK, 8'h0D, 8'h0A);
        push_seq(8'h20); push_trl(MARK, 8'h0D, 8'h0A);
        wait_idle(400);
        check("midrst_err_le1", 32'(err_cnt <= 1), 32'd1);
        check("midrst_frame_cnt1", 32'(frame_cnt), 32'd1);

        // error saturation at 2 bits, then enable drop
        do_reset();
        for (int f = 0; f < 5; f++) begin
            push_seq(8'h10); push_trl(8'hAA, 8'h0D, 8'h0A);
        end
        wait_idle(1000);
        check("sat_err_cnt", 32'(err_cnt), 32'd3);
        push_seq(8'h00);
        repeat (2) @(negedge clk);
        en_req = 0;
        repeat (2) @(negedge clk);
        check("en0_rdreq", 32'(fifo_rdreq), 32'd0);
        check("en0_fifo_nonempty", 32'(fq.size() > 0), 32'd1);
        check("sat_err_hold", 32'(err_cnt), 32'd3);
        en_req = 1;
        wait_idle(300);

        // randomized frames with corruption, starvation and enable toggling
        do_reset();
        starve = 1; rand_en = 1; rand_rd = 1;
        for (int f = 0; f < 24; f++) begin
            int kind = $urandom_range(0, 5);
            int ns = (kind == 2) ? 20 : NCH;
            for (int i = 0; i < ns; i++) fq.push_back(rnd_byte());
            push_trl((kind == 0) ? rnd_byte() : MARK,
                     (kind == 1) ? rnd_byte() : 8'h0D, 8'h0A);
        end
        wait_idle(6000);
        starve = 0; rand_en = 0; rand_rd = 0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
